// File: rtl/joypad_reg.sv
// joypad_reg: Game Boy P1/JOYP register (default address 0xFF00).
// Takes the debounced button levels and press pulses. Exposes the selected
// button group to the CPU, and raises a one-cycle joypad interrupt when any
// visible bit falls. A programmable holdoff limits how often the interrupt
// can fire.
// Build option: define JOYPAD_LATCH_EN to add sticky press bits. A press is
// then held visible until the CPU reads the group it belongs to.
module joypad_reg #(
  parameter logic [15:0] ADDR        = 16'hFF00,
  parameter int          INT_HOLDOFF = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  held,
  input  logic [7:0]  press,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        hit,
  output logic        int_req
);

  localparam int HOLDOFF_W = (INT_HOLDOFF < 1) ? 1 : $clog2(INT_HOLDOFF + 1);
  localparam logic [HOLDOFF_W-1:0] HOLD_LOAD = HOLDOFF_W'(INT_HOLDOFF);

  logic [1:0]           r_sel;
  logic [3:0]           r_prev_nib;
  logic                 r_pending;
  logic [HOLDOFF_W-1:0] r_hold_cnt;
  logic                 r_int_req;

  logic       w_addr_match;
  logic       w_rd_hit;
  logic       w_wr_hit;
  logic [7:0] w_eff;
  logic [3:0] w_dir_n;
  logic [3:0] w_btn_n;
  logic [3:0] w_nib;
  logic       w_edge;
  logic       w_fire;
  logic       w_unused_din;

  assign w_addr_match = (a == ADDR);
  assign w_rd_hit     = rd && w_addr_match;
  assign w_wr_hit     = wr && w_addr_match;
  assign hit          = (rd || wr) && w_addr_match;
  assign w_unused_din = ^{din[7:6], din[3:0]};

`ifdef JOYPAD_LATCH_EN
  logic [7:0] r_sticky;
  logic [7:0] w_clr;

  // A read clears only the groups it exposed. A press arriving in the same
  // cycle re-sets its bit, so that press is not lost.
  assign w_clr = {{4{w_rd_hit & ~r_sel[1]}}, {4{w_rd_hit & ~r_sel[0]}}};
  assign w_eff = held | r_sticky;

  // Sticky press capture with clear-on-read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sticky <= 8'h00;
    else       r_sticky <= (r_sticky & ~w_clr) | press;
  end
`else
  logic w_unused_press;
  assign w_unused_press = ^press;
  assign w_eff          = held;
`endif

  assign w_dir_n = ~w_eff[3:0];
  assign w_btn_n = ~w_eff[7:4];

  // Visible nibble as selected by P15/P14 (low = group selected).
  always_comb begin
    w_nib = 4'hF;
    case (r_sel)
      2'b10:   w_nib = w_dir_n;
      2'b01:   w_nib = w_btn_n;
      2'b00:   w_nib = w_dir_n & w_btn_n;
      default: w_nib = 4'hF;
    endcase
  end

  assign dout = w_rd_hit ? {2'b11, r_sel, w_nib} : 8'hFF;

  // Any visible bit falling counts, including falls caused by a select change.
  // Fire when the holdoff has expired and there is either a new fall or a
  // fall still waiting from earlier. Both at once produce a single pulse.
  assign w_edge = |(r_prev_nib & ~w_nib);
  assign w_fire = (w_edge || r_pending) && (r_hold_cnt == '0);

  // Select register. A new value changes the visible nibble from the next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_sel <= 2'b11;
    else if (w_wr_hit) r_sel <= din[5:4];
  end

  // Interrupt generation with holdoff. A fall that arrives during the
  // holdoff is queued and fires once the holdoff expires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_nib <= 4'hF;
      r_pending  <= 1'b0;
      r_hold_cnt <= '0;
      r_int_req  <= 1'b0;
    end else begin
      r_prev_nib <= w_nib;
      if (w_fire) begin
        r_int_req  <= 1'b1;
        r_pending  <= 1'b0;
        r_hold_cnt <= HOLD_LOAD;
      end else begin
        r_int_req <= 1'b0;
        if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
        if (w_edge)           r_pending  <= 1'b1;
      end
    end
  end

  assign int_req = r_int_req;

endmodule
